// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit.
//   - funct3 encodings of the conditional branches
//   - 2-bit saturating counter encodings and their update function
//   - BTB entry layout (valid, tag, target, counter)
package branch_pkg;

   // Width of the tag/target fields stored in a BTB entry. Instances must
   // use XLEN <= ADDR_W; narrower addresses are zero-extended on write.
   localparam int ADDR_W = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] tag;
      logic [ADDR_W-1:0] target;
      logic [1:0]        ctr;
   } btb_entry_t;

   // Saturating 2-bit counter step toward the resolved direction.
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
      end
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Branch comparator link.
//   br_un    : request unsigned compare (BLTU/BGEU)
//   br_less  : rs1 < rs2 under the requested signedness
//   br_equal : rs1 == rs2
// master = branch_resolve (consumer of the result), slave = comparator.
interface branch_resolve_if;
   logic br_un;
   logic br_less;
   logic br_equal;

   modport master (output br_un, input br_less, input br_equal);
   modport slave  (input br_un, output br_less, output br_equal);
endinterface

// File: rtl/branch_resolve_btb.sv
// Direct-mapped BTB storage.
//   clk, rst        : clock, synchronous active-high reset (clears every entry)
//   rd_idx_a/rd_a   : combinational read port (fetch lookup)
//   rd_idx_b/rd_b   : combinational read port (EX-stage hit check)
//   wr_en/idx/data  : single write port, applied on the rising edge
// Reads never see a same-cycle write; they return the stored value.
module btb_table
   import branch_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_a,
   output btb_entry_t       rd_a,
   input  logic [IDX_W-1:0] rd_idx_b,
   output btb_entry_t       rd_b,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  btb_entry_t       wr_data
);

   btb_entry_t mem [ENTRIES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_a = mem[rd_idx_a];
   assign rd_b = mem[rd_idx_b];

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve unit.
//   clk, rst          : clock, synchronous active-high reset
//   if_pc             : fetch PC; pred_taken/pred_target are its BTB prediction
//   ex_*              : EX-stage instruction, its decoded kind, target and the
//                       prediction carried from fetch
//   cmp               : comparator link (br_un out, br_less/br_equal in)
//   redirect_valid/pc : registered one-cycle redirect on a mispredict
//   flush             : same as redirect_valid, kills IF/ID
//   branch_count      : resolved control transfers (wraps)
//   mispredict_count  : redirects issued (wraps)
module branch_resolve
   import branch_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   parameter int IDX_W       = $clog2(BTB_ENTRIES),
   parameter int XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_stall,
   input  logic            ex_is_branch,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   branch_resolve_if.master cmp,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispredict_count
);

   localparam int TAG_W = XLEN - IDX_W - 2;

   // ---------------- fetch lookup ----------------
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   btb_entry_t       f_ent;
   logic             f_hit;

   assign f_idx = if_pc[IDX_W+1:2];
   assign f_tag = if_pc[XLEN-1:IDX_W+2];
   assign f_hit = f_ent.valid && (f_ent.tag == ADDR_W'(f_tag));

   assign pred_taken  = f_hit && f_ent.ctr[1];
   assign pred_target = pred_taken ? XLEN'(f_ent.target) : '0;

   // ---------------- EX resolve ----------------
   logic [IDX_W-1:0] e_idx;
   logic [TAG_W-1:0] e_tag;
   btb_entry_t       e_ent;
   logic             e_hit;
   logic             fire;
   logic             counted;
   logic             taken;
   logic             mispredict;
   logic [XLEN-1:0]  correct_pc;

   assign e_idx = ex_pc[IDX_W+1:2];
   assign e_tag = ex_pc[XLEN-1:IDX_W+2];
   assign e_hit = e_ent.valid && (e_ent.tag == ADDR_W'(e_tag));

   assign cmp.br_un = ex_funct3[1];

   // The instruction sitting in EX while a redirect is out is wrong-path.
   assign fire = ex_valid && !ex_stall && !redirect_valid;

   always_comb begin
      counted = 1'b0;
      taken   = 1'b0;
      if (ex_is_jal || ex_is_jalr) begin
         counted = 1'b1;
         taken   = 1'b1;
      end else if (ex_is_branch) begin
         counted = 1'b1;
         case (ex_funct3)
            F3_BEQ:           taken = cmp.br_equal;
            F3_BNE:           taken = !cmp.br_equal;
            F3_BLT, F3_BLTU:  taken = cmp.br_less;
            F3_BGE, F3_BGEU:  taken = !cmp.br_less;
            default:          counted = 1'b0;
         endcase
      end
   end

   assign mispredict = fire && counted &&
                       ((taken != ex_pred_taken) ||
                        (taken && (ex_target != ex_pred_target)));

   assign correct_pc = taken ? ex_target : ex_pc + XLEN'(4);

   // ---------------- BTB update ----------------
   logic       wr_en;
   btb_entry_t wr_data;

   always_comb begin
      wr_en   = 1'b0;
      wr_data = e_ent;
      if (fire && counted && !ex_is_jalr) begin
         if (ex_is_jal) begin
            wr_en   = 1'b1;
            wr_data = '{valid: 1'b1, tag: ADDR_W'(e_tag),
                        target: ADDR_W'(ex_target), ctr: CTR_ST};
         end else if (e_hit) begin
            wr_en       = 1'b1;
            wr_data.ctr = ctr_update(e_ent.ctr, taken);
            if (taken) begin
               wr_data.target = ADDR_W'(ex_target);
            end
         end else if (taken) begin
            wr_en   = 1'b1;
            wr_data = '{valid: 1'b1, tag: ADDR_W'(e_tag),
                        target: ADDR_W'(ex_target), ctr: CTR_WT};
         end
      end
   end

   btb_table #(
      .ENTRIES (BTB_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_btb (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_a (f_idx),
      .rd_a     (f_ent),
      .rd_idx_b (e_idx),
      .rd_b     (e_ent),
      .wr_en    (wr_en),
      .wr_idx   (e_idx),
      .wr_data  (wr_data)
   );

   // ---------------- redirect and perf counters ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         redirect_valid <= mispredict;
         if (mispredict) begin
            redirect_pc <= correct_pc;
         end
         if (fire && counted) begin
            branch_count <= branch_count + 32'd1;
         end
         if (mispredict) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end

   assign flush = redirect_valid;

   // PC byte-offset bits and the counter's low bit at fetch carry no information here.
   logic unused_bits;
   assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], f_ent.ctr[0]};

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the BTB,
// redirect register and performance counters.
module tb_branch_resolve;

   localparam int N = 16;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_target, ex_pred_target;
   logic        ex_pred_taken;
   logic        br_less, br_equal;
   logic        redirect_valid, flush;
   logic [31:0] redirect_pc, branch_count, mispredict_count;

   branch_resolve_if cmp_if();
   assign cmp_if.br_less  = br_less;
   assign cmp_if.br_equal = br_equal;

   branch_resolve #(
      .BTB_ENTRIES (N),
      .XLEN        (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_stall         (ex_stall),
      .ex_is_branch     (ex_is_branch),
      .ex_is_jal        (ex_is_jal),
      .ex_is_jalr       (ex_is_jalr),
      .ex_funct3        (ex_funct3),
      .ex_pc            (ex_pc),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .cmp              (cmp_if),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_known = 1'b0;
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];
   bit          m_rv;
   logic [31:0] m_rpc, m_bc, m_mc;

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc / 4) % N;
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc / (4 * N);
   endfunction

   task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
      int unsigned i;
      i  = idx_of(pc);
      t  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : 32'h0;
   endtask

   task automatic model_step();
      bit fire, cnt, tk, mis, hit;
      int unsigned i;
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
         end
         m_rv = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
         m_known = 1'b1;
         return;
      end
      fire = ex_valid && !ex_stall && !m_rv;
      cnt  = 0;
      tk   = 0;
      if (ex_is_jal || ex_is_jalr) begin
         cnt = 1; tk = 1;
      end else if (ex_is_branch) begin
         cnt = 1;
         if (ex_funct3 == 3'd0)                            tk = br_equal;
         else if (ex_funct3 == 3'd1)                       tk = !br_equal;
         else if (ex_funct3 == 3'd4 || ex_funct3 == 3'd6)  tk = br_less;
         else if (ex_funct3 == 3'd5 || ex_funct3 == 3'd7)  tk = !br_less;
         else                                              cnt = 0;
      end
      mis = fire && cnt && ((tk != ex_pred_taken) || (tk && ex_target != ex_pred_target));
      if (fire && cnt) m_bc = m_bc + 1;
      if (mis) begin
         m_mc  = m_mc + 1;
         m_rpc = tk ? ex_target : ex_pc + 4;
      end
      m_rv = mis;
      if (fire && cnt && !ex_is_jalr) begin
         i   = idx_of(ex_pc);
         hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
         if (ex_is_jal) begin
            m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; m_ctr[i] = 3;
         end else if (hit) begin
            if (tk) begin
               if (m_ctr[i] < 3) m_ctr[i]++;
               m_tgt[i] = ex_target;
            end else if (m_ctr[i] > 0) begin
               m_ctr[i]--;
            end
         end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; m_ctr[i] = 2;
         end
      end
   endtask

   // Inputs are applied just after a falling edge; combinational outputs are
   // sampled 1 time unit later, registered outputs 1 time unit after the rise.
   task automatic tick();
      bit          pt;
      logic [31:0] ptg;
      bit          un;
      #1;
      if (m_known) begin
         model_pred(if_pc, pt, ptg);
         check("pred_taken", 32'(pred_taken), 32'(pt));
         check("pred_target", pred_target, ptg);
      end
      un = (ex_funct3 == 3'd2) || (ex_funct3 == 3'd3) || (ex_funct3 == 3'd6) || (ex_funct3 == 3'd7);
      check("br_un", 32'(cmp_if.br_un), 32'(un));
      model_step();
      @(posedge clk);
      #1;
      check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      check("flush", 32'(flush), 32'(m_rv));
      check("redirect_pc", redirect_pc, m_rpc);
      check("branch_count", branch_count, m_bc);
      check("mispredict_count", mispredict_count, m_mc);
      @(negedge clk);
   endtask

   task automatic idle();
      ex_valid = 0; ex_stall = 0;
      ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
   endtask

   // kind: 0 conditional branch, 1 JAL, 2 JALR
   task automatic set_ex(input int kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input bit pt, input logic [31:0] ptg,
                         input bit less, input bit eq);
      ex_valid = 1; ex_stall = 0;
      ex_is_branch = (kind == 0); ex_is_jal = (kind == 1); ex_is_jalr = (kind == 2);
      ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
      ex_pred_taken = pt; ex_pred_target = ptg;
      br_less = less; br_equal = eq;
   endtask

   initial begin
      bit          pt;
      logic [31:0] ptg;
      int          k;
      rst = 1; if_pc = 32'h100; idle();
      ex_funct3 = 0; ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
      br_less = 0; br_equal = 0;
      @(negedge clk);
      tick();
      rst = 0;
      check("rst_pred_taken", 32'(pred_taken), 32'h0);
      check("rst_pred_target", pred_target, 32'h0);
      check("rst_branch_count", branch_count, 32'h0);
      check("rst_mispredict_count", mispredict_count, 32'h0);

      // BEQ taken, first encounter
      set_ex(0, 3'b000, 32'h100, 32'h140, 0, 32'h0, 0, 1);
      tick();
      check("beq_redirect", 32'(redirect_valid), 32'h1);
      check("beq_redirect_pc", redirect_pc, 32'h140);
      check("beq_alloc_pred", 32'(pred_taken), 32'h1);
      check("beq_alloc_target", pred_target, 32'h140);
      idle();
      tick();
      check("beq_pulse_end", 32'(redirect_valid), 32'h0);

      // br_un follows unsigned compares
      ex_funct3 = 3'b110;
      #1 check("bltu_un", 32'(cmp_if.br_un), 32'h1);
      ex_funct3 = 3'b101;
      #1 check("bge_un", 32'(cmp_if.br_un), 32'h0);
      @(negedge clk);
      set_ex(0, 3'b101, 32'h180, 32'h1c0, 0, 32'h0, 1, 0);
      tick();
      check("bge_no_redirect", 32'(redirect_valid), 32'h0);
      check("bge_count", branch_count, 32'd2);
      check("bge_mis_count", mispredict_count, 32'd1);

      // train, then not taken
      for (int r = 0; r < 3; r++) begin
         set_ex(0, 3'b000, 32'h100, 32'h140, 1, 32'h140, 0, 1);
         tick();
      end
      set_ex(0, 3'b000, 32'h100, 32'h140, 1, 32'h140, 0, 0);
      tick();
      check("nt_redirect_pc", redirect_pc, 32'h104);
      check("nt_still_pred", 32'(pred_taken), 32'h1);
      set_ex(0, 3'b000, 32'h100, 32'h140, 0, 32'h0, 0, 1);
      tick();
      check("wrong_path_count", branch_count, 32'd6);
      check("wrong_path_no_redirect", 32'(redirect_valid), 32'h0);

      // JALR aliases index 0 but must not touch the BTB
      set_ex(2, 3'b000, 32'h200, 32'h300, 0, 32'h0, 0, 0);
      tick();
      check("jalr_redirect_pc", redirect_pc, 32'h300);
      check("jalr_keeps_entry", 32'(pred_taken), 32'h1);
      idle(); if_pc = 32'h200;
      tick();
      check("jalr_no_alloc", 32'(pred_taken), 32'h0);
      set_ex(0, 3'b010, 32'h100, 32'h140, 1, 32'h140, 0, 0);
      tick();
      check("f3_010_no_redirect", 32'(redirect_valid), 32'h0);
      check("f3_010_no_count", branch_count, 32'd7);

      // reset on the cycle a mispredict fires
      if_pc = 32'h100;
      set_ex(0, 3'b000, 32'h100, 32'h140, 1, 32'h140, 0, 0);
      rst = 1;
      tick();
      rst = 0;
      check("rst_mid_redirect", 32'(redirect_valid), 32'h0);
      check("rst_mid_count", branch_count, 32'h0);
      check("rst_mid_btb", 32'(pred_taken), 32'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         k   = $urandom_range(0, 5);
         ex_pc = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 1)) * 32'h400;
         if_pc = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 1)) * 32'h400;
         model_pred(ex_pc, pt, ptg);
         if ($urandom_range(0, 9) >= 7) begin
            pt  = $urandom_range(0, 1);
            ptg = 32'h100 + 32'($urandom_range(0, 15)) * 4;
         end
         set_ex((k < 4) ? 0 : k - 3, 3'($urandom_range(0, 7)), ex_pc,
                32'h100 + 32'($urandom_range(0, 15)) * 4, pt, ptg,
                $urandom_range(0, 1), $urandom_range(0, 1));
         ex_valid = ($urandom_range(0, 3) != 0);
         ex_stall = ($urandom_range(0, 4) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
